id_ex_pipe: RTL and testbench

ID/EX pipeline register with integrated EX-hazard stall control. It captures decoded ID-stage operands and control (operands already forwarded from MEM/WB) and presents them to EX one cycle later. EX-result forwarding into ID is not provided, so this block detects any read in ID of a register that EX will write. On such a hazard it stalls IF/ID and injects a one-cycle bubble into EX. It also tracks the branch-delay-slot flag and counts injected bubbles.

---
 rtl/id_ex_pipe_if.sv | 52 +++++
 rtl/id_ex_pipe.sv | 93 +++++++++
 tb/tb_id_ex_pipe.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_pipe_if.sv
// ID/EX stage bundle: decoded ID operands/control in, registered EX copies and stall
// control out. The pipe register attaches as slave; the ID-side driver attaches as master.
interface id_ex_pipe_if #(
    parameter int unsigned CNT_W = 16
);
    logic             flush;
    logic             stall_ex;
    logic             id_valid;
    logic             id_re1;
    logic             id_re2;
    logic [4:0]       id_raddr1;
    logic [4:0]       id_raddr2;
    logic [31:0]      id_pc;
    logic [31:0]      id_inst;
    logic [7:0]       id_aluop;
    logic [2:0]       id_alusel;
    logic [31:0]      id_reg1;
    logic [31:0]      id_reg2;
    logic             id_we;
    logic [4:0]       id_waddr;
    logic             id_is_in_delayslot;
    logic             id_next_in_delayslot;

    logic [31:0]      ex_pc;
    logic [31:0]      ex_inst;
    logic [7:0]       ex_aluop;
    logic [2:0]       ex_alusel;
    logic [31:0]      ex_reg1;
    logic [31:0]      ex_reg2;
    logic             ex_we;
    logic [4:0]       ex_waddr;
    logic             ex_is_in_delayslot;
    logic             is_in_delayslot;
    logic             stall;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output flush, stall_ex, id_valid, id_re1, id_re2, id_raddr1, id_raddr2,
               id_pc, id_inst, id_aluop, id_alusel, id_reg1, id_reg2, id_we, id_waddr,
               id_is_in_delayslot, id_next_in_delayslot,
        input  ex_pc, ex_inst, ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_we, ex_waddr,
               ex_is_in_delayslot, is_in_delayslot, stall, bubble_cnt
    );

    modport slave (
        input  flush, stall_ex, id_valid, id_re1, id_re2, id_raddr1, id_raddr2,
               id_pc, id_inst, id_aluop, id_alusel, id_reg1, id_reg2, id_we, id_waddr,
               id_is_in_delayslot, id_next_in_delayslot,
        output ex_pc, ex_inst, ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_we, ex_waddr,
               ex_is_in_delayslot, is_in_delayslot, stall, bubble_cnt
    );
endinterface

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with EX-hazard detection: a read in ID of the register EX is
// about to write stalls IF/ID and injects one bubble, counted by a saturating counter.
module id_ex_pipe #(
    parameter int unsigned CNT_W = 16
) (
    input logic         clk_i,
    input logic         rst_i,
    id_ex_pipe_if.slave bus
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic        we;
        logic [4:0]  waddr;
        logic        ds;
    } ex_t;

    ex_t              ex_q, ex_d, id_payload;
    logic             ds_q, ds_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             haz1, haz2, hazard;

    // Compared against our own registered outputs, so the bubble clears ex_we and the
    // hazard resolves after exactly one cycle.
    assign haz1 = bus.id_valid & bus.id_re1 & (bus.id_raddr1 != 5'd0) & ex_q.we &
                  (ex_q.waddr == bus.id_raddr1);
    assign haz2 = bus.id_valid & bus.id_re2 & (bus.id_raddr2 != 5'd0) & ex_q.we &
                  (ex_q.waddr == bus.id_raddr2);
    assign hazard = haz1 | haz2;

    assign id_payload = '{
        pc:     bus.id_pc,
        inst:   bus.id_inst,
        aluop:  bus.id_aluop,
        alusel: bus.id_alusel,
        reg1:   bus.id_reg1,
        reg2:   bus.id_reg2,
        we:     bus.id_we,
        waddr:  bus.id_waddr,
        ds:     bus.id_is_in_delayslot
    };

    always_comb begin
        ex_d  = ex_q;
        ds_d  = ds_q;
        cnt_d = cnt_q;
        if (bus.flush) begin
            ex_d = '0;
            ds_d = 1'b0;
        end else if (bus.stall_ex) begin
            // hold everything, including a pending hazard
        end else if (hazard) begin
            ex_d = '0;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            ex_d = bus.id_valid ? id_payload : '0;
            ds_d = bus.id_next_in_delayslot;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q  <= '0;
            ds_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            ds_q  <= ds_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.ex_pc              = ex_q.pc;
    assign bus.ex_inst            = ex_q.inst;
    assign bus.ex_aluop           = ex_q.aluop;
    assign bus.ex_alusel          = ex_q.alusel;
    assign bus.ex_reg1            = ex_q.reg1;
    assign bus.ex_reg2            = ex_q.reg2;
    assign bus.ex_we              = ex_q.we;
    assign bus.ex_waddr           = ex_q.waddr;
    assign bus.ex_is_in_delayslot = ex_q.ds;
    assign bus.is_in_delayslot    = ds_q;
    assign bus.stall              = bus.stall_ex | hazard;
    assign bus.bubble_cnt         = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe: expected EX state is queued when each step is driven and
// popped for comparison just after the clock edge that should produce it.
module tb_id_ex_pipe;

    localparam int unsigned CNT_W = 2;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      inst;
        logic [7:0]       aluop;
        logic [2:0]       alusel;
        logic [31:0]      reg1;
        logic [31:0]      reg2;
        logic             we;
        logic [4:0]       waddr;
        logic             ex_ds;
        logic             ds;
        logic [CNT_W-1:0] cnt;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    obs_t  exp_q[$];
    string tag_q[$];

    id_ex_pipe_if #(.CNT_W(CNT_W)) bus ();

    id_ex_pipe #(.CNT_W(CNT_W)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic obs_t observe();
        return '{pc: bus.ex_pc, inst: bus.ex_inst, aluop: bus.ex_aluop,
                 alusel: bus.ex_alusel, reg1: bus.ex_reg1, reg2: bus.ex_reg2,
                 we: bus.ex_we, waddr: bus.ex_waddr, ex_ds: bus.ex_is_in_delayslot,
                 ds: bus.is_in_delayslot, cnt: bus.bubble_cnt};
    endfunction

    // EX state expected after a clean load of what ID currently presents.
    function automatic obs_t loaded(input logic ds, input logic [CNT_W-1:0] cnt);
        obs_t o;
        o = '0;
        if (bus.id_valid) begin
            o = '{pc: bus.id_pc, inst: bus.id_inst, aluop: bus.id_aluop,
                  alusel: bus.id_alusel, reg1: bus.id_reg1, reg2: bus.id_reg2,
                  we: bus.id_we, waddr: bus.id_waddr, ex_ds: bus.id_is_in_delayslot,
                  ds: 1'b0, cnt: '0};
        end
        o.ds  = ds;
        o.cnt = cnt;
        return o;
    endfunction

    function automatic obs_t nop(input logic ds, input logic [CNT_W-1:0] cnt);
        obs_t o;
        o = '0;
        o.ds  = ds;
        o.cnt = cnt;
        return o;
    endfunction

    task automatic check_stall(input string tag, input logic expv);
        total++;
        assert (bus.stall === expv) else begin
            bad++;
            $error("FAIL %s stall observed=%b expected=%b", tag, bus.stall, expv);
        end
    endtask

    task automatic tick(input string tag, input obs_t expv);
        obs_t  e, o;
        string t;
        exp_q.push_back(expv);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = observe();
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", t, o, e);
        end
    endtask

    task automatic idle();
        bus.flush = 0; bus.stall_ex = 0; bus.id_valid = 0;
        bus.id_re1 = 0; bus.id_re2 = 0; bus.id_raddr1 = 0; bus.id_raddr2 = 0;
        bus.id_pc = 0; bus.id_inst = 0; bus.id_aluop = 0; bus.id_alusel = 0;
        bus.id_reg1 = 0; bus.id_reg2 = 0; bus.id_we = 0; bus.id_waddr = 0;
        bus.id_is_in_delayslot = 0; bus.id_next_in_delayslot = 0;
    endtask

    task automatic instr(input logic [31:0] pc, input logic [31:0] r1, input logic we,
                         input logic [4:0] waddr);
        idle();
        bus.id_valid = 1; bus.id_pc = pc; bus.id_inst = pc ^ 32'hA5A5_0000;
        bus.id_aluop = pc[7:0] ^ 8'h21; bus.id_alusel = 3'd1;
        bus.id_reg1 = r1; bus.id_reg2 = r1 + 32'h11; bus.id_we = we; bus.id_waddr = waddr;
    endtask

    logic [CNT_W-1:0] c;

    initial begin
        // Reset with garbage on ID.
        instr(32'hDEAD, 32'h99, 1, 5'd7);
        tick("reset1", nop(0, 0));
        tick("reset2", nop(0, 0));
        rst = 0;
        #1;
        check_stall("reset_stall", 0);

        instr(32'h100, 32'h11, 1, 5'd3);
        bus.id_re1 = 1; bus.id_raddr1 = 5'd4;
        #1 check_stall("nohaz_stall", 0);
        tick("load_100", loaded(0, 0));

        instr(32'h104, 32'h44, 1, 5'd5);
        bus.id_re1 = 1; bus.id_raddr1 = 5'd1;
        #1 check_stall("nohaz2_stall", 0);
        tick("load_104", loaded(0, 0));

        // RAW on r5: one bubble, then the held ID instruction loads.
        instr(32'h108, 32'h33, 1, 5'd6);
        bus.id_re1 = 1; bus.id_raddr1 = 5'd5; bus.id_is_in_delayslot = 1;
        #1 check_stall("raw_stall", 1);
        tick("raw_bubble", nop(0, 1));
        check_stall("raw_resolved", 0);
        tick("raw_load", loaded(0, 1));

        instr(32'h10C, 32'h55, 1, 5'd0);
        tick("load_w0", loaded(0, 1));
        instr(32'h110, 32'h66, 1, 5'd7);
        bus.id_re1 = 1; bus.id_raddr1 = 5'd0;
        #1 check_stall("r0_stall", 0);
        tick("load_110", loaded(0, 1));

        // EX writes r7: disabled read and invalid ID must not stall.
        instr(32'h114, 32'h77, 1, 5'd9);
        bus.id_re2 = 0; bus.id_raddr2 = 5'd7; bus.id_next_in_delayslot = 1;
        #1 check_stall("re2_off_stall", 0);
        bus.id_valid = 0; bus.id_re1 = 1; bus.id_raddr1 = 5'd7;
        #1 check_stall("invalid_stall", 0);
        bus.id_valid = 1; bus.id_re1 = 0;
        tick("branch_load", loaded(1, 1));

        // Hazard on r9 plus downstream stall: hold, no bubble.
        instr(32'h118, 32'h88, 1, 5'd2);
        bus.id_re2 = 1; bus.id_raddr2 = 5'd9; bus.stall_ex = 1;
        #1 check_stall("hold_stall", 1);
        tick("hold", observe());
        total++;
        assert (bus.ex_pc === 32'h114 && bus.bubble_cnt === 2'd1) else begin
            bad++;
            $error("FAIL hold_values observed=%h/%0d expected=114/1", bus.ex_pc, bus.bubble_cnt);
        end
        bus.flush = 1;
        tick("flush", nop(0, 1));
        idle();
        bus.stall_ex = 1;
        #1 check_stall("stall_ex_only", 1);

        // Saturation: five more bubbles with a 2-bit counter.
        c = 2'd1;
        for (int i = 0; i < 5; i++) begin
            instr(32'h200 + 32'(i * 8), 32'(i), 1, 5'd10);
            tick("sat_prod", loaded(0, c));
            instr(32'h204 + 32'(i * 8), 32'(i + 100), 0, 5'd11);
            bus.id_re1 = 1; bus.id_raddr1 = 5'd10;
            #1 check_stall("sat_stall", 1);
            c = (c == 2'd3) ? 2'd3 : c + 2'd1;
            tick("sat_bubble", nop(0, c));
            tick("sat_cons", loaded(0, c));
        end
        total++;
        assert (bus.bubble_cnt === 2'd3) else begin
            bad++;
            $error("FAIL saturate observed=%0d expected=3", bus.bubble_cnt);
        end

        instr(32'h300, 32'h1, 1, 5'd12);
        bus.id_valid = 0; bus.id_next_in_delayslot = 1;
        tick("invalid_load", nop(1, 3));

        // Reset during a hazard stall.
        instr(32'h304, 32'h2, 1, 5'd13);
        tick("pre_rst", loaded(0, 3));
        bus.id_re1 = 1; bus.id_raddr1 = 5'd13;
        #1 check_stall("pre_rst_stall", 1);
        rst = 1;
        tick("mid_rst", nop(0, 0));
        check_stall("post_rst_stall", 0);
        rst = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
